// File: rtl/fifo_cache_pkg.sv
// rtl/fifo_cache_pkg.sv - shared types and default geometry for the fifo_cache request controller
package fifo_cache_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_CACHE_SIZE = 4;
  localparam int RSP_ID_W       = $clog2(DEF_NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } ctrl_state_t;

  // Response record at the default geometry, field order matches the rsp_* ports
  typedef struct packed {
    logic [RSP_ID_W-1:0]       id;
    logic                      hit;
    logic                      evict_valid;
    logic [DEF_ADDR_WIDTH-1:0] evict_addr;
  } ctrl_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant starting one past the previous winner
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic [IDW-1:0]     last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     grant_idx_o
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDW'((int'(last_grant_i) + i) % NUM_REQ);
      if (en_i && !found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_cache_ctrl.sv
// rtl/fifo_cache_ctrl.sv - arbitrates requesters onto a single fifo_cache port and returns tagged responses
module fifo_cache_ctrl
  import fifo_cache_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int CACHE_SIZE = DEF_CACHE_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 16,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic                          rsp_hit,
  output logic                          rsp_evict_valid,
  output logic [ADDR_WIDTH-1:0]         rsp_evict_addr,
  output logic [ADDR_WIDTH-1:0]         cache_address,
  output logic                          cache_read_write,
  input  logic                          cache_hit,
  input  logic [ADDR_WIDTH-1:0]         cache_evicted_address,
  output logic [CNT_WIDTH-1:0]          hit_count,
  output logic [CNT_WIDTH-1:0]          miss_count,
  output logic [CNT_WIDTH-1:0]          evict_count
);

  localparam int FW = $clog2(CACHE_SIZE + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(CACHE_SIZE);

  ctrl_state_t             state_q, state_d;
  logic [IDW-1:0]          last_q, last_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic                    hit_q, hit_d;
  logic                    evict_q, evict_d;
  logic [ADDR_WIDTH-1:0]   evict_addr_q, evict_addr_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic [CNT_WIDTH-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0]    evict_cnt_q, evict_cnt_d;
  logic [NUM_REQ-1:0]      grant;
  logic [IDW-1:0]          grant_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i        (req_valid),
    .en_i         ((state_q == ST_IDLE) && !reset),
    .last_grant_i (last_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    id_d             = id_q;
    addr_d           = addr_q;
    write_d          = write_q;
    hit_d            = hit_q;
    evict_d          = evict_q;
    evict_addr_d     = evict_addr_q;
    fill_d           = fill_q;
    hit_cnt_d        = hit_cnt_q;
    miss_cnt_d       = miss_cnt_q;
    evict_cnt_d      = evict_cnt_q;
    cache_read_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          addr_d  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          write_d = req_write[grant_idx];
          id_d    = grant_idx;
          last_d  = grant_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The cache commits this access on the closing edge, so fill_q tracks its insertion pointer
        cache_read_write = write_q;
        hit_d   = cache_hit;
        evict_d = write_q && !cache_hit && (fill_q == FILL_FULL);
        if (write_q && !cache_hit && (fill_q != FILL_FULL)) fill_d = fill_q + FW'(1);
        if (cache_hit) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
        end
        if (evict_d && (evict_cnt_q != '1)) evict_cnt_d = evict_cnt_q + CNT_WIDTH'(1);
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        evict_addr_d = evict_q ? cache_evicted_address : '0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_q       <= IDW'(NUM_REQ - 1);
      id_q         <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      hit_q        <= 1'b0;
      evict_q      <= 1'b0;
      evict_addr_q <= '0;
      fill_q       <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      evict_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      hit_q        <= hit_d;
      evict_q      <= evict_d;
      evict_addr_q <= evict_addr_d;
      fill_q       <= fill_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      evict_cnt_q  <= evict_cnt_d;
    end
  end

  assign req_ready       = grant;
  assign rsp_valid       = (state_q == ST_RESP);
  assign rsp_id          = id_q;
  assign rsp_hit         = hit_q;
  assign rsp_evict_valid = evict_q;
  assign rsp_evict_addr  = evict_addr_q;
  assign cache_address   = addr_q;
  assign hit_count       = hit_cnt_q;
  assign miss_count      = miss_cnt_q;
  assign evict_count     = evict_cnt_q;

endmodule

// File: tb/tb_fifo_cache_ctrl.sv
// tb/tb_fifo_cache_ctrl.sv - scoreboard bench for fifo_cache_ctrl with a behavioural FIFO cache attached
module tb_fifo_cache_ctrl;
  import fifo_cache_pkg::*;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int CS = 4;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   req_write;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic            rsp_hit;
  logic            rsp_evict_valid;
  logic [AW-1:0]   rsp_evict_addr;
  logic [AW-1:0]   cache_address;
  logic            cache_read_write;
  logic            cache_hit;
  logic [AW-1:0]   cache_evicted_address;
  logic [CW-1:0]   hit_count, miss_count, evict_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  ctrl_rsp_t exp_q[$];
  ctrl_rsp_t mon_e;

  fifo_cache_ctrl #(.NUM_REQ(NR), .CACHE_SIZE(CS), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_hit(rsp_hit),
    .rsp_evict_valid(rsp_evict_valid), .rsp_evict_addr(rsp_evict_addr),
    .cache_address(cache_address), .cache_read_write(cache_read_write),
    .cache_hit(cache_hit), .cache_evicted_address(cache_evicted_address),
    .hit_count(hit_count), .miss_count(miss_count), .evict_count(evict_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural fifo_cache: combinational hit, registered evicted address, FIFO replacement
  logic [AW-1:0] cm_entry [CS];
  logic [CS-1:0] cm_valid;
  int            cm_ptr;
  logic [AW-1:0] cm_ev;

  always_comb begin
    cache_hit = 1'b0;
    for (int i = 0; i < CS; i++)
      if (cm_valid[i] && cm_entry[i] == cache_address) cache_hit = 1'b1;
  end

  always @(posedge clk) begin
    if (reset) begin
      cm_valid <= '0;
      cm_ptr   <= 0;
      cm_ev    <= '0;
    end else if (cache_read_write && !cache_hit) begin
      cm_ev            <= cm_valid[cm_ptr] ? cm_entry[cm_ptr] : '0;
      cm_entry[cm_ptr] <= cache_address;
      cm_valid[cm_ptr] <= 1'b1;
      cm_ptr           <= (cm_ptr + 1) % CS;
    end
  end
  assign cache_evicted_address = cm_ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d hit %0b ev %0b addr 0x%0h expected no response",
                 rsp_id, rsp_hit, rsp_evict_valid, rsp_evict_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp", 32'({rsp_id, rsp_hit, rsp_evict_valid, rsp_evict_addr}), 32'(mon_e));
      end
    end
  end

  task automatic do_req(input int r, input logic [AW-1:0] a, input logic w,
                        input logic eh, input logic ev, input logic [AW-1:0] ea);
    bit got;
    @(posedge clk); #1;
    req_valid[r]         = 1'b1;
    req_addr[r*AW +: AW] = a;
    req_write[r]         = w;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
    end
    if (!got) timeout_fail("grant");
    else begin
      acc_cyc = cyc;
      exp_q.push_back('{id: RSP_ID_W'(r), hit: eh, evict_valid: ev, evict_addr: ea});
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || rsp_valid) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 100) timeout_fail("drain");
  endtask

  task automatic wait_rsp_valid(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    if (!got) timeout_fail(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int n;
    int k;
    ctrl_rsp_t e;
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_cache_addr", 32'({cache_read_write, cache_address}), 0);
    chk("rst_counters", 32'(hit_count | miss_count | evict_count), 0);
    chk("rst_rsp_fields", 32'({rsp_id, rsp_hit, rsp_evict_valid, rsp_evict_addr}), 0);

    // First write: accept in T, response visible in T+3
    do_req(0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00);
    wait_rsp_valid("first_rsp");
    chk("latency", 32'(cyc - acc_cyc), 3);
    wait_idle();
    chk("miss_after_first", 32'(miss_count), 1);

    do_req(1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00);
    do_req(2, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00);
    do_req(3, 8'h44, 1'b1, 1'b0, 1'b0, 8'h00);
    do_req(0, 8'h55, 1'b1, 1'b0, 1'b1, 8'h11);
    wait_idle();
    chk("evict_after_fill", 32'(evict_count), 1);

    do_req(1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00);
    do_req(2, 8'h66, 1'b1, 1'b0, 1'b1, 8'h22);
    do_req(3, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00);
    do_req(0, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00);
    wait_idle();
    chk("hit_count", 32'(hit_count), 1);
    chk("miss_count", 32'(miss_count), 8);
    chk("evict_count", 32'(evict_count), 2);

    // Back-pressure: response must hold while a competing request waits
    rsp_ready = 1'b0;
    do_req(2, 8'h77, 1'b1, 1'b0, 1'b1, 8'h33);
    wait_rsp_valid("stall_rsp");
    @(posedge clk); #1;
    req_valid[3] = 1'b1;
    req_addr[3*AW +: AW] = 8'hAB;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_fields", 32'({rsp_id, rsp_hit, rsp_evict_valid, rsp_evict_addr}), 32'({2'd2, 1'b0, 1'b1, 8'h33}));
      chk("stall_no_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    rsp_ready    = 1'b1;
    wait_idle();

    rsp_ready = 1'b0;
    do_req(0, 8'h88, 1'b1, 1'b0, 1'b1, 8'h44);
    wait_rsp_valid("reset_rsp");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_counters", 32'({hit_count, miss_count} | 32'(evict_count)), 0);
    reset = 1'b0;
    exp_q.delete();
    rsp_ready = 1'b1;

    // All requesters valid: round-robin from requester 0
    req_valid = 4'hF;
    req_write = 4'hF;
    req_addr  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    n = 0;
    k = 0;
    while (n < 5 && k < 100) begin
      @(negedge clk);
      k++;
      if (req_ready != '0) begin
        chk("rr_grant", 32'(req_ready), 32'(1 << order[n]));
        e = '{id: RSP_ID_W'(order[n]), hit: (n == 4), evict_valid: 1'b0, evict_addr: 8'h00};
        exp_q.push_back(e);
        n++;
      end
    end
    if (n < 5) timeout_fail("rr_grants");
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    chk("rr_counts", 32'({hit_count[7:0], miss_count[7:0], evict_count[7:0]}), 32'({8'd1, 8'd4, 8'd0}));
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
